// File: rtl/alto_disk_word.sv
// Alto disk word task: bit-cell timing, read deserializer, write serializer,
// word-task wakeup and data-late detection.
module alto_disk_word #(
  parameter int BIT_DIV   = 8,
  parameter int WORD_BITS = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [3:0]  current_task_i,
  input  logic [2:0]  bs_i,
  input  logic [3:0]  f1_i,
  input  logic [15:0] bus_i,
  output logic [15:0] bus_o,
  input  logic        xferoff_i,
  input  logic        wdinhib_i,
  input  logic        wffo_i,
  input  logic        write_mode_i,
  input  logic        clr_late_i,
  input  logic        serial_data_i,
  output logic        serial_data_o,
  output logic        write_gate_o,
  output logic        word_req_o,
  output logic        wd_init_o,
  output logic        data_late_o
);

  // state   | meaning
  // S_IDLE  | transfer off; timer, bit count and shifters held clear
  // S_HUNT  | read with WFFO: waiting for the sync 1 bit
  // S_SHIFT | assembling (read) or emitting (write) 16-bit words

  localparam logic [3:0] ALTO_TASK_DISK_WORD     = 4'd14;
  localparam logic [3:0] ALTO_F1_BLOCK           = 4'd2;
  localparam logic [3:0] ALTO_DISK_F1_KDATA_LOAD = 4'd15;
  localparam logic [2:0] ALTO_DISK_BS_KDAT       = 3'd4;
  localparam int TW = $clog2(BIT_DIV);
  localparam logic [TW-1:0] TMAX = TW'(BIT_DIV - 1);

  typedef enum logic [1:0] {S_IDLE, S_HUNT, S_SHIFT} state_t;

  state_t               r_state, w_state_nxt;
  logic [TW-1:0]        r_timer;
  logic [3:0]           r_bit_cnt;
  logic [WORD_BITS-2:0] r_shift_in;
  logic [WORD_BITS-1:0] r_shift_out;
  logic [WORD_BITS-1:0] r_kdata_read;
  logic [WORD_BITS-1:0] r_kdata_write;
  logic                 r_wr;
  logic                 r_word_req;
  logic                 r_wd_init;
  logic                 r_data_late;

  logic w_tick, w_word_task, w_block, w_kload, w_boundary, w_late, w_enter_shift;

  assign w_tick        = (r_state != S_IDLE) && (r_timer == TMAX);
  assign w_word_task   = (current_task_i == ALTO_TASK_DISK_WORD);
  assign w_block       = w_word_task && (f1_i == ALTO_F1_BLOCK);
  assign w_kload       = w_word_task && (f1_i == ALTO_DISK_F1_KDATA_LOAD);
  assign w_boundary    = w_tick && (r_state == S_SHIFT) && (r_bit_cnt == 4'hF) && !xferoff_i;
  // A BLOCK landing on the boundary counts as serviced in time.
  assign w_late        = w_boundary && r_word_req && !w_block;
  assign w_enter_shift = (r_state != S_SHIFT) && (w_state_nxt == S_SHIFT);

  always_comb begin
    w_state_nxt = r_state;
    if (xferoff_i) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  w_state_nxt = (wffo_i && !write_mode_i) ? S_HUNT : S_SHIFT;
        S_HUNT:  if (w_tick && serial_data_i) w_state_nxt = S_SHIFT;
        default: w_state_nxt = r_state;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_timer       <= '0;
      r_bit_cnt     <= '0;
      r_shift_in    <= '0;
      r_shift_out   <= '0;
      r_kdata_read  <= '0;
      r_kdata_write <= '0;
      r_wr          <= 1'b0;
      r_word_req    <= 1'b0;
      r_wd_init     <= 1'b0;
      r_data_late   <= 1'b0;
    end else begin
      if (r_state == S_IDLE || xferoff_i) r_timer <= '0;
      else if (r_timer == TMAX)            r_timer <= '0;
      else                                 r_timer <= r_timer + 1'b1;

      if (r_state != S_SHIFT || xferoff_i) r_bit_cnt <= '0;
      else if (w_tick)                     r_bit_cnt <= r_bit_cnt + 4'd1;

      if (r_state != S_SHIFT)  r_shift_in <= '0;
      else if (w_tick)         r_shift_in <= {r_shift_in[WORD_BITS-3:0], serial_data_i};

      if (w_boundary && !r_wr) r_kdata_read <= {r_shift_in, serial_data_i};

      // Shifter is cleared while idle so the first write word is a zero preamble.
      if (r_state == S_IDLE) begin
        r_shift_out <= '0;
      end else if (r_state == S_SHIFT && r_wr && w_tick) begin
        if (w_boundary) r_shift_out <= (w_late || r_data_late) ? '0 : r_kdata_write;
        else            r_shift_out <= {r_shift_out[WORD_BITS-2:0], 1'b0};
      end

      if (r_state == S_IDLE) r_wr <= write_mode_i;

      if (xferoff_i)                          r_word_req <= 1'b0;
      else if (w_boundary)                    r_word_req <= ~wdinhib_i;
      else if (w_block)                       r_word_req <= 1'b0;
      else if (w_enter_shift && r_state == S_IDLE && write_mode_i)
                                              r_word_req <= 1'b1;

      if (xferoff_i)          r_wd_init <= 1'b0;
      else if (w_enter_shift) r_wd_init <= 1'b1;
      else if (w_block)       r_wd_init <= 1'b0;

      if (w_late)          r_data_late <= 1'b1;
      else if (clr_late_i) r_data_late <= 1'b0;

      if (w_kload) r_kdata_write <= bus_i;
    end
  end

  assign bus_o         = (w_word_task && bs_i == ALTO_DISK_BS_KDAT) ? r_kdata_read : 16'hFFFF;
  assign serial_data_o = r_shift_out[WORD_BITS-1];
  assign write_gate_o  = (r_state == S_SHIFT) && r_wr;
  assign word_req_o    = r_word_req;
  assign wd_init_o     = r_wd_init;
  assign data_late_o   = r_data_late;

endmodule

// File: tb/tb_alto_disk_word.sv
// Directed/randomized bench for alto_disk_word with BIT_DIV=4; expectations
// come from a word-level model of wakeups, lateness and the serial streams.
module tb_alto_disk_word;
  localparam int BD = 4;
  localparam logic [3:0] T_DW  = 4'd14;
  localparam logic [3:0] F_BLK = 4'd2;
  localparam logic [3:0] F_KLD = 4'd15;
  localparam logic [2:0] B_KD  = 3'd4;

  logic clk = 1'b0;
  logic rst, xferoff, wdinhib, wffo, wmode, clr, sin;
  logic [3:0] task_i, f1;
  logic [2:0] bs;
  logic [15:0] bus_in;
  logic [15:0] bus_out;
  logic sout, wgate, wreq, winit, dlate;

  int n_tests = 0;
  int n_fail  = 0;
  bit exp_req, exp_late, exp_init;
  logic [15:0] kbuf, cur_word, w;

  always #5 clk = ~clk;

  alto_disk_word #(.BIT_DIV(BD), .WORD_BITS(16)) dut (
    .clk_i(clk), .rst_i(rst), .current_task_i(task_i), .bs_i(bs), .f1_i(f1),
    .bus_i(bus_in), .bus_o(bus_out), .xferoff_i(xferoff), .wdinhib_i(wdinhib),
    .wffo_i(wffo), .write_mode_i(wmode), .clr_late_i(clr), .serial_data_i(sin),
    .serial_data_o(sout), .write_gate_o(wgate), .word_req_o(wreq),
    .wd_init_o(winit), .data_late_o(dlate)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One read bit cell; BLOCK and clear-late can be pulsed on a chosen cycle.
  task automatic rd_cell(input logic b, input int blk_step, input int clr_step);
    sin = b;
    for (int s = 0; s < BD; s++) begin
      if (s == blk_step) f1 = F_BLK;
      if (s == clr_step) clr = 1'b1;
      step();
      f1  = 4'd0;
      clr = 1'b0;
    end
  endtask

  task automatic send_word(input logic [15:0] wd, input bit blk_first, input bit blk_last,
                           input bit clr_first, input string tag);
    for (int i = 0; i < 15; i++)
      rd_cell(wd[15-i], (i == 0 && blk_first) ? 0 : -1, (i == 0 && clr_first) ? 1 : -1);
    if (blk_first) begin exp_req = 1'b0; exp_init = 1'b0; end
    if (clr_first) exp_late = 1'b0;
    sin = wd[0];
    repeat (BD - 1) step();
    check({tag, "_req_pre"}, 16'(wreq), 16'(exp_req));
    if (blk_last) f1 = F_BLK;
    step();
    f1 = 4'd0;
    if (exp_req && !blk_last) exp_late = 1'b1;
    exp_req = !wdinhib;
    if (blk_last) exp_init = 1'b0;
    check({tag, "_req"},  16'(wreq),  16'(exp_req));
    check({tag, "_late"}, 16'(dlate), 16'(exp_late));
    check({tag, "_init"}, 16'(winit), 16'(exp_init));
    bs = B_KD;
    #1;
    check({tag, "_kdat"}, bus_out, wd);
    bs = 3'd0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; xferoff = 1'b1; wdinhib = 1'b0; wffo = 1'b0; wmode = 1'b0;
    clr = 1'b0; sin = 1'b0; task_i = T_DW; f1 = 4'd0; bs = 3'd0; bus_in = 16'h0;
    kbuf = 16'h0; exp_req = 0; exp_late = 0; exp_init = 0;
    repeat (3) step();
    rst = 1'b0;
    step();

    check("rst_bus_idle", bus_out, 16'hFFFF);
    bs = B_KD; #1;
    check("rst_bus_kdat", bus_out, 16'h0000);
    task_i = 4'd5; #1;
    check("rst_bus_othertask", bus_out, 16'hFFFF);
    task_i = T_DW; bs = 3'd0;
    check("rst_req",   16'(wreq),  16'h0);
    check("rst_late",  16'(dlate), 16'h0);
    check("rst_init",  16'(winit), 16'h0);
    check("rst_wgate", 16'(wgate), 16'h0);
    check("rst_sout",  16'(sout),  16'h0);
    for (int i = 0; i < 40; i++) begin
      sin = 1'($urandom);
      step();
    end
    check("xferoff_hold_req",  16'(wreq),  16'h0);
    check("xferoff_hold_init", 16'(winit), 16'h0);

    // Read transfer hunting for sync: 0,0,1 then data words.
    wffo = 1'b1; wmode = 1'b0; xferoff = 1'b0;
    step();
    rd_cell(1'b0, -1, -1);
    rd_cell(1'b0, -1, -1);
    check("hunt_init", 16'(winit), 16'h0);
    rd_cell(1'b1, -1, -1);
    exp_init = 1'b1;
    check("sync_init", 16'(winit), 16'h1);
    check("sync_req",  16'(wreq),  16'h0);
    send_word(16'hA5C3, 1'b0, 1'b0, 1'b0, "rd_w1");
    w = 16'($urandom); send_word(w, 1'b1, 1'b0, 1'b0, "rd_w2");
    w = 16'($urandom); send_word(w, 1'b0, 1'b0, 1'b0, "rd_w3_late");
    w = 16'($urandom); send_word(w, 1'b0, 1'b1, 1'b1, "rd_w4_blkedge");
    wdinhib = 1'b1;
    w = 16'($urandom); send_word(w, 1'b1, 1'b0, 1'b0, "rd_w5_inhib");

    // Second read transfer with a random run of leading zeros.
    xferoff = 1'b1; step();
    exp_req = 1'b0; exp_init = 1'b0;
    wdinhib = 1'b0; xferoff = 1'b0;
    step();
    for (int i = $urandom_range(5, 1); i > 0; i--) rd_cell(1'b0, -1, -1);
    rd_cell(1'b1, -1, -1);
    exp_init = 1'b1;
    w = 16'($urandom); send_word(w, 1'b0, 1'b0, 1'b0, "rd2_w1");

    // Write transfer.
    xferoff = 1'b1; step();
    clr = 1'b1; step(); clr = 1'b0;
    exp_req = 1'b0; exp_init = 1'b0; exp_late = 1'b0;
    check("wr_pre_late", 16'(dlate), 16'h0);
    wmode = 1'b1; xferoff = 1'b0;
    step();
    exp_req = 1'b1; exp_init = 1'b1;
    check("wr_entry_req",   16'(wreq),  16'h1);
    check("wr_entry_init",  16'(winit), 16'h1);
    check("wr_entry_wgate", 16'(wgate), 16'h1);
    cur_word = 16'h0000;
    for (int wi = 0; wi < 4; wi++) begin
      for (int c = 0; c < 16; c++) begin
        if (wi == 3 && c == 5) begin
          xferoff = 1'b1;
          step();
          check("abort_wgate", 16'(wgate), 16'h0);
          check("abort_req",   16'(wreq),  16'h0);
          check("abort_init",  16'(winit), 16'h0);
          check("abort_late",  16'(dlate), 16'h1);
          break;
        end
        if ((wi == 0 && c == 2) || (wi == 1 && c == 1)) begin
          kbuf = (wi == 0) ? 16'h8001 : 16'($urandom);
          f1 = F_KLD; bus_in = kbuf;
        end
        if ((wi == 0 && c == 3) || (wi == 1 && c == 4)) begin
          f1 = F_BLK; exp_req = 1'b0; exp_init = 1'b0;
        end
        step();
        f1 = 4'd0;
        check($sformatf("wr_w%0d_b%0d", wi, c), 16'(sout), 16'(cur_word[15-c]));
        if (c == 0) check($sformatf("wr_w%0d_wgate", wi), 16'(wgate), 16'h1);
        repeat (BD - 1) step();
        if (c == 15) begin
          if (exp_req) exp_late = 1'b1;
          cur_word = exp_late ? 16'h0000 : kbuf;
          exp_req = 1'b1;
          check($sformatf("wr_w%0d_req", wi),  16'(wreq),  16'(exp_req));
          check($sformatf("wr_w%0d_late", wi), 16'(dlate), 16'(exp_late));
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/alto_disk_word.md
Name: alto_disk_word

Overview:
- Word-task side of the Alto disk controller; sits between the emulated drive serial bit stream and the microcoded disk word task.
- Generates the bit clock and deserializes read data into 16-bit words, or serializes KDATA writes.
- Raises the word-task wakeup once per word and detects data-late overruns.
- Takes its controls from the KCOMM/KSTAT side of the controller: xferoff, wdinhib, wffo, the write mode and the clear-status pulse.

Parameters:
BIT_DIV, 8, system clocks per disk bit cell (minimum 2).
WORD_BITS, 16, bits per word (fixed at 16; the parameter is for documentation only).

Ports:
clk_i  in  1  system clock
rst_i  in  1  synchronous reset, active-high
current_task_i  in  4  running microcode task
bs_i  in  3  bus source field
f1_i  in  4  F1 field
bus_i  in  16  processor bus
bus_o  out  16  bus drive; 16'hFFFF when not driving (wired-AND bus)
xferoff_i  in  1  KCOMM XFEROFF; 1 = transfer disabled
wdinhib_i  in  1  KCOMM WDINHIB; 1 = suppress word wakeups
wffo_i  in  1  KCOMM WFFO; 1 = hunt for sync bit before assembling words
write_mode_i  in  1  1 = write, 0 = read (decoded from the current KADR record action)
clr_late_i  in  1  one-cycle clear pulse from the CLRSTAT decode
serial_data_i  in  1  read bit stream from drive, sampled on bit tick
serial_data_o  out  1  write bit stream to drive
write_gate_o  out  1  drive write enable
word_req_o  out  1  disk word task wakeup
wd_init_o  out  1  WDINIT; feeds the sector block's init modifier (37 octal)
data_late_o  out  1  sticky overrun flag, goes to KSTAT

Behaviour:
Reset (synchronous, active-high) sets:
- all outputs to 0, except bus_o = 16'hFFFF
- state IDLE; bit timer 0, bit_cnt 0
- shift registers, kdata_read and kdata_write buffer all 0

States: IDLE, HUNT, SHIFT.
- IDLE: enter immediately (next edge) whenever xferoff_i=1, from any state.
  - Clears word_req_o, write_gate_o and wd_init_o; timer and bit_cnt held at 0.
  - Exit when xferoff_i=0: to HUNT if wffo_i=1 and write_mode_i=0, else to SHIFT.
  - On any entry into SHIFT from IDLE, wd_init_o <= 1.
- Bit tick: timer counts 0..BIT_DIV-1 while not in IDLE; tick is the cycle with timer = BIT_DIV-1.
- HUNT (read only): on each tick sample serial_data_i. On the first 1: the sync bit is discarded, go to SHIFT with bit_cnt=0 and shift-in=0, and set wd_init_o <= 1.
- SHIFT read, on each tick:
  - shift_in <= {shift_in[14:0], serial_data_i}; bit_cnt++ (4-bit, wraps).
  - On the tick where bit_cnt = 15: kdata_read <= assembled word (including this bit); this is the word boundary.
- SHIFT write:
  - write_gate_o = 1 while in SHIFT and write_mode_i = 1.
  - serial_data_o = shift_out[15]; shift left on each tick.
  - At the word boundary (tick with bit_cnt = 15), shift_out is loaded from the kdata_write buffer. If data late, it is loaded with 16'h0000 instead.
- Word boundary actions (read and write):
  - If word_req_o is still 1, data_late_o <= 1.
  - word_req_o <= ~wdinhib_i.
- First wakeup in write mode: word_req_o is set on SHIFT entry so microcode preloads the first word. The first 16 bits shifted out are 0, acting as preamble.
- word_req_o clears when current_task_i = ALTO_TASK_DISK_WORD and f1_i = ALTO_F1_BLOCK. If this coincides with a word boundary set, the set wins and no late is flagged for that boundary.
- wd_init_o clears on the first BLOCK executed by the word task.
- data_late_o clears on clr_late_i. If a late event occurs in the same cycle, the set wins.
- kdata_write buffer <= bus_i when the word task is running and f1_i = ALTO_DISK_F1_KDATA_LOAD.
- bus_o (combinational) = kdata_read when current_task_i = ALTO_TASK_DISK_WORD and bs_i = ALTO_DISK_BS_KDAT; otherwise 16'hFFFF.
- Changing write_mode_i or wffo_i mid-transfer takes effect only via a pass through IDLE.

Test Plan (BIT_DIV=4):
- Reset: after reset, bus_o=FFFF, word_req_o=0, data_late_o=0, state IDLE; holding xferoff_i=1 → no ticks and no wakeups.
- Read with WFFO: xferoff_i=0, wffo_i=1, stream 0,0,1 then 16'hA5C3 MSB-first → word_req_o rises 64 clocks after the sync-bit tick; a BS KDAT read on the word task returns 16'hA5C3; wd_init_o=1 until BLOCK.
- Overrun: read two words with no BLOCK between them → data_late_o=1 at the second boundary; clr_late_i → 0; BLOCK on the exact boundary cycle → word_req_o stays 1 and no late is flagged.
- Write: write_mode_i=1, xferoff_i=0 → word_req_o=1 immediately; KDATA_LOAD 16'h8001 then BLOCK → 16 zero bits, then 1,0×14,1 on serial_data_o; write_gate_o=1 throughout.
- Write late: no KDATA_LOAD/BLOCK before the boundary → data_late_o=1 and 16'h0000 is shifted out.
- Abort: xferoff_i=1 mid-word → next edge IDLE, write_gate_o=0, word_req_o=0; wdinhib_i=1 → boundaries occur but word_req_o stays 0.
